br_load_sequencer: RTL and testbench

Sequences every load of the 10-bit buffer register (BR bits 1,2,3,4,5,7,8,10,11,13) and arbitrates between its two sources: memory readout through the sense amplifiers of modules a–d, and transfer from the translator register (TR) in Y or Z syllable halves. For each granted request it issues a one-cycle clear strobe, then the matching set/gate strobe. It then waits one settle cycle and returns a one-cycle acknowledge. The block sits between the memory/TR control logic and the buffer register strobe inputs (`AnCBRVN`, `AnSBRYV`, `AnSBRZV`, sense-amp gating).

---
 rtl/br_load_sequencer.sv | 156 +++++++++++++++
 tb/tb_br_load_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/br_load_sequencer.sv
// br_load_sequencer: clear/set/settle/acknowledge sequencing for every load of
// the buffer register, arbitrating between memory readout and TR transfer.
// Optional build macro: BRSEQ_STARVE_GUARD_EN (TR starvation guard on memory priority).
module br_load_sequencer #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inhibit,
  input  logic       mem_req,
  input  logic [1:0] mem_mod,
  output logic       mem_ack,
  input  logic       tr_req,
  input  logic       tr_syl,
  output logic       tr_ack,
  output logic       cbr_n,
  output logic       sbrz,
  output logic       sbry,
  output logic [3:0] sa_en,
  output logic       busy
);

  localparam int unsigned SET_W = 2;
  localparam int unsigned SA_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              src_tr_q, src_tr_d;
  logic [1:0]        mod_q, mod_d;
  logic              syl_q, syl_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              starve;

  logic              cbr_n_q, cbr_n_d;
  logic              sbrz_q, sbrz_d;
  logic              sbry_q, sbry_d;
  logic [SA_W-1:0]   sa_en_q, sa_en_d;
  logic              mem_ack_q, mem_ack_d;
  logic              tr_ack_q, tr_ack_d;
  logic              busy_q, busy_d;

`ifdef BRSEQ_STARVE_GUARD_EN
  localparam int unsigned CNT_W = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign starve = (cnt_q == CNT_W'(STARVE_LIM));

  // Count memory grants made while TR waits; any TR grant or uncontested memory grant clears it
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && state_d == S_CLEAR) begin
      if (src_tr_d || !tr_req) cnt_d = '0;
      else                     cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_starve_lim;

  assign unused_starve_lim = ^32'(STARVE_LIM);
  assign starve            = 1'b0;
`endif

  // Next state, grant latching and next registered output values
  always_comb begin
    state_d  = state_q;
    src_tr_d = src_tr_q;
    mod_d    = mod_q;
    syl_d    = syl_q;
    settle_d = settle_q;

    case (state_q)
      S_IDLE: begin
        if (!inhibit && (mem_req || tr_req)) begin
          src_tr_d = tr_req && (!mem_req || starve);
          mod_d    = mem_mod;
          syl_d    = tr_syl;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) state_d = S_DONE;
        else                                    settle_d = settle_q + SET_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cbr_n_d   = (state_d != S_CLEAR);
    sbrz_d    = (state_d == S_LOAD) && src_tr_d && !syl_d;
    sbry_d    = (state_d == S_LOAD) && src_tr_d && syl_d;
    sa_en_d   = ((state_d == S_LOAD) && !src_tr_d) ? (SA_W'(1) << mod_d) : '0;
    mem_ack_d = (state_d == S_DONE) && !src_tr_d;
    tr_ack_d  = (state_d == S_DONE) && src_tr_d;
    busy_d    = (state_d != S_IDLE);
  end

  // State, latched grant and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_tr_q  <= 1'b0;
      mod_q     <= '0;
      syl_q     <= 1'b0;
      settle_q  <= '0;
      cbr_n_q   <= 1'b1;
      sbrz_q    <= 1'b0;
      sbry_q    <= 1'b0;
      sa_en_q   <= '0;
      mem_ack_q <= 1'b0;
      tr_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_tr_q  <= src_tr_d;
      mod_q     <= mod_d;
      syl_q     <= syl_d;
      settle_q  <= settle_d;
      cbr_n_q   <= cbr_n_d;
      sbrz_q    <= sbrz_d;
      sbry_q    <= sbry_d;
      sa_en_q   <= sa_en_d;
      mem_ack_q <= mem_ack_d;
      tr_ack_q  <= tr_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign cbr_n   = cbr_n_q;
  assign sbrz    = sbrz_q;
  assign sbry    = sbry_q;
  assign sa_en   = sa_en_q;
  assign mem_ack = mem_ack_q;
  assign tr_ack  = tr_ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_br_load_sequencer.sv
// tb_br_load_sequencer: directed and random stimulus for br_load_sequencer
// against a transaction-level schedule model of grants and their strobe timing.
module tb_br_load_sequencer;

  localparam int S   = 1;
  localparam int LIM = 3;
`ifdef BRSEQ_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk, rst_n, inhibit, mem_req, tr_req, tr_syl;
  logic [1:0] mem_mod;
  logic       mem_ack, tr_ack, cbr_n, sbrz, sbry, busy;
  logic [3:0] sa_en;
  logic [9:0] dut_vec;

  br_load_sequencer #(.SETTLE_CYC(S), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .inhibit(inhibit),
    .mem_req(mem_req), .mem_mod(mem_mod), .mem_ack(mem_ack),
    .tr_req(tr_req), .tr_syl(tr_syl), .tr_ack(tr_ack),
    .cbr_n(cbr_n), .sbrz(sbrz), .sbry(sbry), .sa_en(sa_en), .busy(busy)
  );

  assign dut_vec = {cbr_n, sbrz, sbry, sa_en, mem_ack, tr_ack, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_mem_ack = 0;
  int n_tr_ack = 0;

  // Model: the most recent grant (edge index, source, operands) and when the next may happen
  int         edge_n = 0;
  int         g_edge = -1;
  int         free_at = 0;
  int         cnt = 0;
  bit         g_tr, g_syl;
  logic [1:0] g_mod;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    g_edge  = -1;
    free_at = 0;
    cnt     = 0;
  endtask

  // A grant is made at any edge once the previous transaction's slot is over
  task automatic model_edge();
    bit starve;
    edge_n++;
    if (rst_n && edge_n >= free_at && !inhibit && (mem_req || tr_req)) begin
      starve = GUARD && (cnt == LIM);
      g_tr   = tr_req && (!mem_req || starve);
      if (g_tr)        cnt = 0;
      else if (tr_req) cnt = cnt + 1;
      else             cnt = 0;
      g_mod   = mem_mod;
      g_syl   = tr_syl;
      g_edge  = edge_n;
      free_at = edge_n + 4 + S;
    end
  endtask

  // Outputs expected in the cycle following edge_n, from offset since the grant edge
  function automatic logic [9:0] expect_vec();
    int         d;
    bit         v, ld, ak;
    logic [3:0] sa;
    d  = edge_n - g_edge;
    v  = (g_edge >= 0) && (d <= 2 + S);
    ld = v && (d == 1);
    ak = v && (d == 2 + S);
    sa = 4'b0000;
    if (ld && !g_tr) sa = 4'b0001 << g_mod;
    return {~(v && d == 0), ld && g_tr && !g_syl, ld && g_tr && g_syl, sa,
            ak && !g_tr, ak && g_tr, v};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("outs", 32'(dut_vec), 32'(expect_vec()));
    chk("excl", 32'($countones({~cbr_n, sbry, sbrz, sa_en}) <= 1), 32'd1);
    if (mem_ack === 1'b1) n_mem_ack++;
    if (tr_ack === 1'b1)  n_tr_ack++;
  endtask

  task automatic wait_ack(input int lim, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      step();
      if (mem_ack === 1'b1 || tr_ack === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; inhibit = 1'b0; mem_req = 1'b0; tr_req = 1'b0;
    mem_mod = 2'd0; tr_syl = 1'b0;

    // Reset state
    step(); step();
    chk("rst_vals", 32'(dut_vec), 32'h200);
    rst_n = 1'b1;
    step();

    // Memory load from module c
    mem_req = 1'b1; mem_mod = 2'd2;
    step(); chk("m_clear", 32'(cbr_n), 32'd0);
    step(); chk("m_sa", 32'(sa_en), 32'h4);
    step(); chk("m_settle", 32'(dut_vec), 32'h201);
    step(); chk("m_ack", 32'(mem_ack), 32'd1);
    mem_req = 1'b0;
    step(); chk("m_idle", 32'(busy), 32'd0);

    // TR loads, Y then Z half
    for (int syl = 1; syl >= 0; syl--) begin
      tr_req = 1'b1; tr_syl = 1'(syl);
      step(); chk("t_clear", 32'(cbr_n), 32'd0);
      step(); chk("t_strobe", 32'({sbry, sbrz}), (syl == 1) ? 32'h2 : 32'h1);
      step();
      step(); chk("t_ack", 32'(tr_ack), 32'd1);
      tr_req = 1'b0;
      step();
    end

    // Both requesters held: arbitration order over 30 cycles
    n_mem_ack = 0; n_tr_ack = 0;
    mem_req = 1'b1; tr_req = 1'b1; mem_mod = 2'd3; tr_syl = 1'b0;
    repeat (30) step();
    mem_req = 1'b0; tr_req = 1'b0;
    repeat (6) step();
    chk("both_mem_acks", 32'(n_mem_ack), GUARD ? 32'd5 : 32'd6);
    chk("both_tr_acks", 32'(n_tr_ack), GUARD ? 32'd1 : 32'd0);

    // Inhibit holds off grants, then does not disturb a running sequence
    inhibit = 1'b1; mem_req = 1'b1; mem_mod = 2'd1;
    for (int i = 0; i < 6; i++) begin
      step(); chk("inh_busy", 32'(busy), 32'd0);
    end
    inhibit = 1'b0;
    step(); chk("rel_busy", 32'(busy), 32'd1);
    step(); chk("rel_sa", 32'(sa_en), 32'h2);
    inhibit = 1'b1;
    wait_ack(8, seen);
    chk("inh_ack", 32'(seen), 32'd1);
    mem_req = 1'b0; inhibit = 1'b0;
    step();

    // Asynchronous reset during LOAD aborts without an ack
    mem_req = 1'b1; mem_mod = 2'd0;
    step(); step();
    chk("ar_load", 32'(sa_en), 32'h1);
    #2 rst_n = 1'b0; mem_req = 1'b0;
    #1;
    chk("ar_sa", 32'(sa_en), 32'h0);
    chk("ar_cbr", 32'(cbr_n), 32'd1);
    chk("ar_busy", 32'(busy), 32'd0);
    model_reset();
    n_mem_ack = 0; n_tr_ack = 0;
    step(); step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("ar_no_ack", 32'(n_mem_ack + n_tr_ack), 32'd0);

    // Random request stream
    for (int i = 0; i < 400; i++) begin
      inhibit = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) mem_req = ~mem_req;
      if ($urandom_range(0, 3) == 0) tr_req = ~tr_req;
      mem_mod = 2'($urandom_range(0, 3));
      tr_syl  = 1'($urandom_range(0, 1));
      step();
    end
    mem_req = 1'b0; tr_req = 1'b0; inhibit = 1'b0;
    repeat (8) step();
    chk("end_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
